// File: rtl/vga_pixel_feeder.sv
// vga_pixel_feeder: frame-locked pixel FIFO for the VGA controller with box overlay and underflow tracking
module vga_pixel_feeder #(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int PREFILL = 8,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter logic [23:0] UNDER_COLOR = 24'h00FF00
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iPix_Valid,
  input  logic [23:0] iPix_Data,
  input  logic        iPix_SOF,
  output logic        oPix_Ready,
  input  logic        iRequest,
  input  logic        iVGA_V_SYNC,
  input  logic        iBox_En,
  input  logic [12:0] iBox_X0,
  input  logic [12:0] iBox_X1,
  input  logic [12:0] iBox_Y0,
  input  logic [12:0] iBox_Y1,
  output logic [7:0]  oRed,
  output logic [7:0]  oGreen,
  output logic [7:0]  oBlue,
  output logic        oUnderflow,
  output logic [15:0] oUnderflow_Cnt,
  output logic        oSync_Lost
);
  localparam logic [ADDR_W:0] PRE = (ADDR_W + 1)'(PREFILL);
  localparam logic [12:0] X_LAST = 13'(H_ACT - 1);
  localparam logic [12:0] Y_LAST = 13'(V_ACT - 1);
  typedef enum logic [1:0] {SEEK, FILL, RUN} state_t;
  state_t state, stateNext;
  logic [24:0] mem [FIFO_DEPTH];
  logic [24:0] head;
  logic [ADDR_W:0] wrPtr, rdPtr, count;
  logic [12:0] x, y, bx0, bx1, by0, by1;
  logic [23:0] pixNext;
  logic ben, vsyncQ, vsFall, full, empty, push, pop, lost, under, onBox;
  assign count = wrPtr - rdPtr;
  assign full = count[ADDR_W];
  assign empty = wrPtr == rdPtr;
  assign head = mem[rdPtr[ADDR_W-1:0]];
  assign vsFall = vsyncQ && !iVGA_V_SYNC;
  assign oPix_Ready = !iRST && (state == SEEK || !full);
  // while seeking, everything is accepted but only the SOF pixel is kept
  assign push = iPix_Valid && oPix_Ready && (state != SEEK || iPix_SOF);
  assign under = state == RUN && iRequest && empty;
  assign lost = state == RUN && iRequest && !empty && (head[24] != (x == '0 && y == '0));
  assign pop = state == RUN && iRequest && !empty && !lost;
  assign onBox = ben && bx0 <= bx1 && by0 <= by1 &&
    (((x == bx0 || x == bx1) && y >= by0 && y <= by1) || ((y == by0 || y == by1) && x >= bx0 && x <= bx1));
  assign pixNext = (state != RUN || lost) ? 24'd0 : under ? UNDER_COLOR : onBox ? BOX_COLOR : head[23:0];
  always_comb begin
    stateNext = state;
    if (state == SEEK && push) stateNext = FILL;
    if (state == FILL && vsFall && count >= PRE) stateNext = RUN;
    if (state == RUN && lost) stateNext = SEEK;
  end
  always_ff @(posedge iCLK) begin
    vsyncQ <= iVGA_V_SYNC;
    if (push) mem[wrPtr[ADDR_W-1:0]] <= {iPix_SOF, iPix_Data};
    if (iRST) begin
      state <= SEEK;
      wrPtr <= '0;
      rdPtr <= '0;
      x <= '0;
      y <= '0;
      {ben, bx0, bx1, by0, by1} <= '0;
      {oRed, oGreen, oBlue} <= '0;
      oUnderflow <= 1'b0;
      oUnderflow_Cnt <= '0;
      oSync_Lost <= 1'b0;
    end else begin
      state <= stateNext;
      wrPtr <= lost ? '0 : wrPtr + (ADDR_W + 1)'(push);
      rdPtr <= lost ? '0 : rdPtr + (ADDR_W + 1)'(pop);
      if (vsFall) begin
        x <= '0;
        y <= '0;
        {ben, bx0, bx1, by0, by1} <= {iBox_En, iBox_X0, iBox_X1, iBox_Y0, iBox_Y1};
      end else if (iRequest) begin
        x <= x == X_LAST ? '0 : x + 13'd1;
        y <= (x == X_LAST && y != Y_LAST) ? y + 13'd1 : y;
      end
      if (iRequest) {oRed, oGreen, oBlue} <= pixNext;
      oUnderflow <= under;
      oUnderflow_Cnt <= (under && oUnderflow_Cnt != 16'hFFFF) ? oUnderflow_Cnt + 16'd1 : oUnderflow_Cnt;
      oSync_Lost <= lost;
    end
  end
endmodule
